// File: rtl/control_fsm.sv
// Multi-cycle control unit: sequences RV32I subset instructions through
// FETCH/DECODE/EXEC/MEM/WB. It drives the strobes and ALU controls of the
// single-cycle datapath, plus a one-cycle PC load enable per retired instruction.
module control_fsm #(
   parameter int unsigned RETIRE_W        = 16,
   parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         ROM_inst,
   input  logic [3:0]          status,
   output logic                RegWrite,
   output logic                PCSrc,
   output logic                ALUSrc,
   output logic [3:0]          ALU_operation,
   output logic                write,
   output logic                MemtoReg,
   output logic [1:0]          immselect,
   output logic                pc_en,
   output logic                illegal,
   output logic [RETIRE_W-1:0] retired
);

   typedef enum logic [2:0] {
      FETCH, DECODE, EXEC, MEM, WB, TRAP
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_SLL = 4'b0100;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;

   state_t               state, state_nx;
   logic [31:0]          ir;
   logic [RETIRE_W-1:0]  retired_q;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       is_r, is_i, is_load, is_store, is_branch, is_legal;
   logic [3:0] alu_sel, exec_op;
   logic       exec_src;
   logic [1:0] exec_imm;
   logic       flag_z, flag_n, flag_v, taken;
   logic       unused_bits;

   assign opcode    = ir[6:0];
   assign funct3    = ir[14:12];
   assign is_r      = (opcode == OP_R);
   assign is_i      = (opcode == OP_I);
   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_branch = (opcode == OP_BRANCH);
   assign is_legal  = is_r | is_i | is_load | is_store | is_branch;

   assign flag_z = status[0];
   assign flag_n = status[1];
   assign flag_v = status[3];

   // Register/immediate fields and the carry flag play no part in control.
   assign unused_bits = ^{ir[31], ir[29:15], ir[11:7], status[2]};

   // State, instruction register and retire counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= FETCH;
         ir        <= 32'h0000_0013;
         retired_q <= '0;
      end else begin
         state <= state_nx;
         if (state == FETCH) ir <= ROM_inst;
         if (pc_en) retired_q <= retired_q + RETIRE_W'(1);
      end
   end

   // ALU controls decoded from IR only; EXEC drives them, MEM/WB hold them.
   always_comb begin
      case (funct3)
         3'b000:  alu_sel = (is_r && ir[30]) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_sel = ALU_SLL;
         3'b010:  alu_sel = ALU_SLT;
         3'b100:  alu_sel = ALU_XOR;
         3'b101:  alu_sel = ALU_SRL;
         3'b110:  alu_sel = ALU_OR;
         3'b111:  alu_sel = ALU_AND;
         default: alu_sel = ALU_ADD;
      endcase
      exec_op  = alu_sel;
      exec_src = 1'b1;
      exec_imm = IMM_I;
      if (is_r) begin
         exec_src = 1'b0;
      end else if (is_store) begin
         exec_op  = ALU_ADD;
         exec_imm = IMM_S;
      end else if (is_load) begin
         exec_op  = ALU_ADD;
      end else if (is_branch) begin
         exec_op  = ALU_SUB;
         exec_src = 1'b0;
         exec_imm = IMM_B;
      end
   end

   // Branch condition from funct3 and the ALU flags of the SUB compare.
   always_comb begin
      case (funct3)
         3'b000:  taken = flag_z;
         3'b001:  taken = ~flag_z;
         3'b100:  taken = flag_n ^ flag_v;
         3'b101:  taken = ~(flag_n ^ flag_v);
         default: taken = 1'b0;
      endcase
   end

   // Next-state and output decode.
   always_comb begin
      state_nx      = state;
      RegWrite      = 1'b0;
      PCSrc         = 1'b0;
      ALUSrc        = 1'b0;
      ALU_operation = ALU_ADD;
      write         = 1'b0;
      MemtoReg      = 1'b1;
      immselect     = IMM_I;
      pc_en         = 1'b0;
      case (state)
         FETCH: state_nx = DECODE;
         DECODE: begin
            if (is_legal) begin
               state_nx = EXEC;
            end else if (TRAP_ON_ILLEGAL) begin
               state_nx = TRAP;
            end else begin
               state_nx = FETCH;
               pc_en    = 1'b1;
            end
         end
         EXEC: begin
            ALU_operation = exec_op;
            ALUSrc        = exec_src;
            immselect     = exec_imm;
            if (is_branch) begin
               PCSrc    = taken;
               pc_en    = 1'b1;
               state_nx = FETCH;
            end else if (is_load || is_store) begin
               state_nx = MEM;
            end else begin
               state_nx = WB;
            end
         end
         MEM: begin
            ALU_operation = exec_op;
            ALUSrc        = exec_src;
            immselect     = exec_imm;
            if (is_store) begin
               write    = 1'b1;
               pc_en    = 1'b1;
               state_nx = FETCH;
            end else begin
               state_nx = WB;
            end
         end
         WB: begin
            ALU_operation = exec_op;
            ALUSrc        = exec_src;
            immselect     = exec_imm;
            RegWrite      = 1'b1;
            MemtoReg      = ~is_load;
            pc_en         = 1'b1;
            state_nx      = FETCH;
         end
         TRAP:    state_nx = TRAP;
         default: state_nx = FETCH;
      endcase
   end

   assign illegal = (state == TRAP);
   assign retired = retired_q;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: directed vector table, hand-written reset/trap/wrap
// sequences and random instructions checked against a per-instruction model.
module tb_control_fsm;

   typedef struct packed {
      logic       regwrite;
      logic       pcsrc;
      logic       alusrc;
      logic [3:0] aluop;
      logic       wr;
      logic       memtoreg;
      logic [1:0] imm;
      logic       pc_en;
      logic       illegal;
   } ctl_t;

   typedef struct {
      logic [31:0] inst;
      logic [3:0]  st;
      int          lat;
      ctl_t        fin;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] rom = 32'h0000_0013;
   logic [3:0]  status = 4'b0000;
   bit          sel = 1'b0;

   logic        rw1, pcs1, as1, wr1, mtr1, pce1, ill1;
   logic [3:0]  op1;
   logic [1:0]  imm1;
   logic [15:0] ret1;
   logic        rw2, pcs2, as2, wr2, mtr2, pce2, ill2;
   logic [3:0]  op2;
   logic [1:0]  imm2;
   logic [3:0]  ret2;

   ctl_t        obs;
   logic [15:0] obs_ret;

   int checks = 0;
   int errors = 0;
   int count  = 0;

   always #5 clk = ~clk;

   control_fsm dut (
      .clk(clk), .reset(reset), .ROM_inst(rom), .status(status),
      .RegWrite(rw1), .PCSrc(pcs1), .ALUSrc(as1), .ALU_operation(op1),
      .write(wr1), .MemtoReg(mtr1), .immselect(imm1), .pc_en(pce1),
      .illegal(ill1), .retired(ret1)
   );

   control_fsm #(.RETIRE_W(4), .TRAP_ON_ILLEGAL(1'b0)) dut2 (
      .clk(clk), .reset(reset), .ROM_inst(rom), .status(status),
      .RegWrite(rw2), .PCSrc(pcs2), .ALUSrc(as2), .ALU_operation(op2),
      .write(wr2), .MemtoReg(mtr2), .immselect(imm2), .pc_en(pce2),
      .illegal(ill2), .retired(ret2)
   );

   // Observe whichever instance the current test targets.
   always_comb begin
      if (sel) begin
         obs     = {rw2, pcs2, as2, op2, wr2, mtr2, imm2, pce2, ill2};
         obs_ret = {12'h000, ret2};
      end else begin
         obs     = {rw1, pcs1, as1, op1, wr1, mtr1, imm1, pce1, ill1};
         obs_ret = ret1;
      end
   end

   function automatic ctl_t mk(input logic rw, input logic pcs, input logic as,
                               input logic [3:0] op, input logic wr, input logic mtr,
                               input logic [1:0] imm, input logic pce);
      ctl_t c;
      c = {rw, pcs, as, op, wr, mtr, imm, pce, 1'b0};
      return c;
   endfunction

   // Instruction class: 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 illegal.
   function automatic int cls(input logic [31:0] inst);
      case (inst[6:0])
         7'b0110011: return 0;
         7'b0010011: return 1;
         7'b0000011: return 2;
         7'b0100011: return 3;
         7'b1100011: return 4;
         default:    return 5;
      endcase
   endfunction

   function automatic int latency(input logic [31:0] inst);
      int tab [6] = '{4, 4, 5, 4, 3, 2};
      return tab[cls(inst)];
   endfunction

   function automatic logic [3:0] alu_of(input logic [31:0] inst);
      logic [3:0] by_f3 [8] = '{4'b0010, 4'b0100, 4'b0111, 4'b0010,
                                4'b0011, 4'b0101, 4'b0001, 4'b0000};
      int k;
      k = cls(inst);
      if (k == 2 || k == 3) return 4'b0010;
      if (k == 4) return 4'b0110;
      if (k == 0 && inst[14:12] == 3'b000 && inst[30]) return 4'b0110;
      return by_f3[inst[14:12]];
   endfunction

   function automatic logic br_taken(input logic [2:0] f3, input logic [3:0] st);
      logic z, lt;
      z  = st[0];
      lt = st[1] ^ st[3];
      if (f3 == 3'b000) return z;
      if (f3 == 3'b001) return !z;
      if (f3 == 3'b100) return lt;
      if (f3 == 3'b101) return !lt;
      return 1'b0;
   endfunction

   // Expected controls in cycle c (1 = FETCH) of a non-trapping instruction.
   function automatic ctl_t model(input logic [31:0] inst, input logic [3:0] st, input int c);
      ctl_t e;
      int   k, lat;
      k   = cls(inst);
      lat = latency(inst);
      e   = mk(0, 0, 0, 4'b0010, 0, 1, 2'b00, 0);
      if (k == 5) begin
         if (c == 2) e.pc_en = 1'b1;
         return e;
      end
      if (c >= 3) begin
         e.aluop  = alu_of(inst);
         e.alusrc = (k == 1 || k == 2 || k == 3);
         e.imm    = (k == 3) ? 2'b01 : (k == 4) ? 2'b10 : 2'b00;
      end
      if (c == lat) begin
         e.pc_en = 1'b1;
         case (k)
            0, 1: e.regwrite = 1'b1;
            2: begin e.regwrite = 1'b1; e.memtoreg = 1'b0; end
            3: e.wr = 1'b1;
            default: e.pcsrc = br_taken(inst[14:12], st);
         endcase
      end
      return e;
   endfunction

   task automatic chk_ctl(input string nm, input ctl_t act, input ctl_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got rw,pcs,as,op,wr,mtr,imm,pce,ill=%b required %b", nm, act, exp);
      end
   endtask

   task automatic chk_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   // Leaves the bench in cycle 1 (FETCH) of the first instruction.
   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk_ctl("reset_outputs", obs, mk(0, 0, 0, 4'b0010, 0, 1, 2'b00, 0));
      chk_val("reset_retired", {16'h0, obs_ret}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      count = 0;
   endtask

   // Enters in cycle 1 of an instruction, leaves in cycle 1 of the next one.
   task automatic run_inst(input string nm, input logic [31:0] inst, input logic [3:0] st,
                           input int lat, input bit use_fin, input ctl_t fin);
      int rw;
      rom    = inst;
      status = st;
      for (int c = 1; c <= lat; c++) begin
         chk_ctl($sformatf("%s_cyc%0d", nm, c), obs, model(inst, st, c));
         if (c == lat && use_fin) chk_ctl($sformatf("%s_final", nm), obs, fin);
         @(posedge clk);
         #2;
      end
      count++;
      rw = sel ? 4 : 16;
      chk_val($sformatf("%s_retired", nm), {16'h0, obs_ret}, count % (1 << rw));
   endtask

   vec_t vt [14];

   initial begin
      logic [6:0]  legal_ops [5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
      logic [6:0]  bad_ops [4]   = '{7'h7F, 7'h00, 7'h37, 7'h6F};
      logic [31:0] ri;
      logic [3:0]  rs;

      vt[0]  = '{32'h002081B3, 4'b0000, 4, mk(1, 0, 0, 4'b0010, 0, 1, 2'b00, 1)}; // add
      vt[1]  = '{32'h0020A223, 4'b0000, 4, mk(0, 0, 1, 4'b0010, 1, 1, 2'b01, 1)}; // sw
      vt[2]  = '{32'h0040A183, 4'b0000, 5, mk(1, 0, 1, 4'b0010, 0, 0, 2'b00, 1)}; // lw
      vt[3]  = '{32'h00208463, 4'b0001, 3, mk(0, 1, 0, 4'b0110, 0, 1, 2'b10, 1)}; // beq Z=1
      vt[4]  = '{32'h00208463, 4'b0000, 3, mk(0, 0, 0, 4'b0110, 0, 1, 2'b10, 1)}; // beq Z=0
      vt[5]  = '{32'h0020C463, 4'b0010, 3, mk(0, 1, 0, 4'b0110, 0, 1, 2'b10, 1)}; // blt N=1 V=0
      vt[6]  = '{32'h402081B3, 4'b0000, 4, mk(1, 0, 0, 4'b0110, 0, 1, 2'b00, 1)}; // sub
      vt[7]  = '{32'h00500093, 4'b0000, 4, mk(1, 0, 1, 4'b0010, 0, 1, 2'b00, 1)}; // addi
      vt[8]  = '{32'h4010D093, 4'b0000, 4, mk(1, 0, 1, 4'b0101, 0, 1, 2'b00, 1)}; // srai -> SRL
      vt[9]  = '{32'h00209463, 4'b0001, 3, mk(0, 0, 0, 4'b0110, 0, 1, 2'b10, 1)}; // bne Z=1
      vt[10] = '{32'h0020D463, 4'b1010, 3, mk(0, 1, 0, 4'b0110, 0, 1, 2'b10, 1)}; // bge N=V=1
      vt[11] = '{32'h0020A463, 4'b0001, 3, mk(0, 0, 0, 4'b0110, 0, 1, 2'b10, 1)}; // f3=010 never
      vt[12] = '{32'h0020F1B3, 4'b0000, 4, mk(1, 0, 0, 4'b0000, 0, 1, 2'b00, 1)}; // and
      vt[13] = '{32'h0020A1B3, 4'b0000, 4, mk(1, 0, 0, 4'b0111, 0, 1, 2'b00, 1)}; // slt

      // Reset mid-EXEC of a sub, then mid-WB of an add.
      sel = 1'b0;
      do_reset();
      rom = 32'h402081B3;
      repeat (2) @(posedge clk);
      #2;
      chk_val("exec_sub_aluop", {28'h0, obs.aluop}, 32'h6);
      reset = 1'b0;
      #1;
      chk_ctl("async_reset_exec", obs, mk(0, 0, 0, 4'b0010, 0, 1, 2'b00, 0));
      @(negedge clk);
      reset = 1'b1;
      #1;
      rom = 32'h002081B3;
      repeat (3) @(posedge clk);
      #2;
      chk_val("wb_regwrite_before_reset", {31'h0, obs.regwrite}, 32'h1);
      reset = 1'b0;
      #1;
      chk_ctl("async_reset_wb", obs, mk(0, 0, 0, 4'b0010, 0, 1, 2'b00, 0));
      chk_val("async_reset_retired", {16'h0, obs_ret}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      count = 0;

      // Directed vector table.
      for (int i = 0; i < 14; i++)
         run_inst($sformatf("vec%0d", i), vt[i].inst, vt[i].st, vt[i].lat, 1'b1, vt[i].fin);

      // Illegal opcode traps and stays there.
      do_reset();
      rom = 32'h0000_007F;
      chk_ctl("trap_cyc1", obs, mk(0, 0, 0, 4'b0010, 0, 1, 2'b00, 0));
      @(posedge clk);
      #2;
      chk_ctl("trap_cyc2", obs, mk(0, 0, 0, 4'b0010, 0, 1, 2'b00, 0));
      rom = 32'h002081B3;
      for (int c = 3; c < 23; c++) begin
         @(posedge clk);
         #2;
         chk_ctl($sformatf("trap_hold%0d", c), obs,
                 {mk(0, 0, 0, 4'b0010, 0, 1, 2'b00, 0)} | 13'h1);
      end
      chk_val("trap_retired", {16'h0, obs_ret}, 32'h0);

      // Illegal opcode retires as a two-cycle NOP, then retire counter wrap.
      sel = 1'b1;
      do_reset();
      run_inst("nop_illegal", 32'h0000_007F, 4'b0000, 2, 1'b1, mk(0, 0, 0, 4'b0010, 0, 1, 2'b00, 1));
      do_reset();
      for (int i = 0; i < 16; i++)
         run_inst($sformatf("wrap_addi%0d", i), 32'h00108093, 4'b0000, 4, 1'b0, '0);
      chk_val("wrap_zero", {16'h0, obs_ret}, 32'h0);

      // Random mix, illegal opcodes included, on the NOP-on-illegal instance.
      for (int i = 0; i < 60; i++) begin
         ri = $urandom;
         rs = 4'($urandom);
         if ($urandom_range(0, 5) == 0) ri[6:0] = bad_ops[$urandom_range(0, 3)];
         else ri[6:0] = legal_ops[$urandom_range(0, 4)];
         run_inst($sformatf("rnd_nop%0d", i), ri, rs, latency(ri), 1'b0, '0);
      end

      // Random legal instructions on the trapping instance.
      sel = 1'b0;
      do_reset();
      for (int i = 0; i < 200; i++) begin
         ri = $urandom;
         rs = 4'($urandom);
         ri[6:0] = legal_ops[$urandom_range(0, 4)];
         run_inst($sformatf("rnd%0d", i), ri, rs, latency(ri), 1'b0, '0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
